// File: rtl/if_stage_fq.sv
// if_stage_fq: instruction-fetch stage feeding decode through a small fetch queue.
// Define IF_PERF_CNT_EN to add the PerfFetched / PerfFlushed counters.
module if_stage_fq #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] PC_RESET   = '0,
  parameter int unsigned     ADDR_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PCBranchD,
  input  logic            PCSrcD,
  input  logic            StallD,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic [31:0]     ImemRD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     PerfFetched,
  output logic [31:0]     PerfFlushed
`endif
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] issue_pc;
  logic [XLEN-1:0] issue_pc4;
  logic [XLEN-1:0] inflight_pc4;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [31:0]     fq_instr [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc4   [FQ_DEPTH];
  logic            push;
  logic            pop;

  assign issue_pc  = PCSrcD ? PCBranchD : pc_f;
  assign issue_pc4 = issue_pc + XLEN'(4);

  // Occupancy counts the response still in flight and ignores a same-cycle pop.
  assign ImemReq  = rst_n & (PCSrcD | ((count + CW'(inflight)) < CW'(FQ_DEPTH)));
  assign ImemAddr = issue_pc >> ADDR_SHIFT;

  assign ValidD   = (count != '0);
  assign InstrD   = fq_instr[rd_ptr];
  assign PCPlus4D = fq_pc4[rd_ptr];

  // A redirect squashes whatever response arrives in the same cycle.
  assign push = inflight & ~PCSrcD;
  assign pop  = ValidD & ~StallD & ~PCSrcD;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f         <= PC_RESET;
      inflight     <= 1'b0;
      inflight_pc4 <= '0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        fq_instr[i] <= '0;
        fq_pc4[i]   <= '0;
      end
    end else begin
      inflight <= ImemReq;
      if (ImemReq) begin
        pc_f         <= issue_pc4;
        inflight_pc4 <= issue_pc4;
      end
      if (PCSrcD) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fq_instr[wr_ptr] <= ImemRD;
          fq_pc4[wr_ptr]   <= inflight_pc4;
          wr_ptr           <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && (count == CW'(FQ_DEPTH))));
  end

`ifdef IF_PERF_CNT_EN
  logic [32:0] fetched_sum;
  logic [32:0] flushed_sum;

  assign fetched_sum = {1'b0, PerfFetched} + 33'(push);
  assign flushed_sum = {1'b0, PerfFlushed} + 33'(count) + 33'(inflight);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PerfFetched <= '0;
      PerfFlushed <= '0;
    end else begin
      PerfFetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      if (PCSrcD) PerfFlushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_fq.sv
// Bench for if_stage_fq: directed scenarios plus random traffic checked against a
// queue-level model of the fetch stage; a second instance covers PC wrap-around.
`timescale 1ns/1ps
module tb_if_stage_fq;

  localparam int          D        = 4;
  localparam logic [31:0] PC_RST   = 32'h0;
  localparam logic [31:0] PC_RST_W = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, PCSrcD, StallD, ImemReq, ValidD;
  logic [31:0] PCBranchD, ImemAddr, ImemRD, InstrD, PCPlus4D;
  logic        rst_w, ImemReq_w, ValidD_w;
  logic [31:0] ImemAddr_w, ImemRD_w, InstrD_w, PCPlus4D_w;
`ifdef IF_PERF_CNT_EN
  logic [31:0] PerfFetched, PerfFlushed, PerfFetched_w, PerfFlushed_w;
  longint      m_fetched, m_flushed;
`endif

  int checks = 0;
  int errors = 0;
  int n_req  = 0;

  if_stage_fq #(.XLEN(32), .FQ_DEPTH(D), .PC_RESET(PC_RST), .ADDR_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .PCBranchD(PCBranchD), .PCSrcD(PCSrcD), .StallD(StallD),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemRD(ImemRD),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef IF_PERF_CNT_EN
    , .PerfFetched(PerfFetched), .PerfFlushed(PerfFlushed)
`endif
  );

  if_stage_fq #(.XLEN(32), .FQ_DEPTH(D), .PC_RESET(PC_RST_W), .ADDR_SHIFT(2)) dut_w (
    .clk(clk), .rst_n(rst_w), .PCBranchD(32'h0), .PCSrcD(1'b0), .StallD(1'b0),
    .ImemReq(ImemReq_w), .ImemAddr(ImemAddr_w), .ImemRD(ImemRD_w),
    .InstrD(InstrD_w), .PCPlus4D(PCPlus4D_w), .ValidD(ValidD_w)
`ifdef IF_PERF_CNT_EN
    , .PerfFetched(PerfFetched_w), .PerfFlushed(PerfFlushed_w)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h11;
  endfunction

  // Memory answers every cycle, so stale data is always on ImemRD for the DUT to ignore.
  always @(posedge clk) begin
    ImemRD   <= memf(ImemAddr);
    ImemRD_w <= memf(ImemAddr_w);
    if (ImemReq) n_req <= n_req + 1;
  end

  logic [63:0] q[$];
  logic        m_infl;
  logic [31:0] m_infl_pc4, m_infl_addr, m_pc;
  bit          armed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [31:0] b, input logic st);
    logic        e_req;
    logic [31:0] e_pc;
    rst_n = r; PCSrcD = s; PCBranchD = b; StallD = st;
    #1;
    e_req = r && (s || (q.size() + int'(m_infl) < D));
    e_pc  = s ? b : m_pc;
    chk("ImemReq", 32'(ImemReq), 32'(e_req));
    if (armed) begin
      chk("ImemAddr", ImemAddr, e_pc >> 2);
      chk("ValidD", 32'(ValidD), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("InstrD", InstrD, q[0][63:32]);
        chk("PCPlus4D", PCPlus4D, q[0][31:0]);
      end
    end
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_infl = 1'b0;
      m_pc   = PC_RST;
`ifdef IF_PERF_CNT_EN
      m_fetched = 0; m_flushed = 0;
`endif
    end else begin
      if (s) begin
`ifdef IF_PERF_CNT_EN
        m_flushed += q.size() + int'(m_infl);
`endif
        q.delete();
      end else begin
        if (q.size() != 0 && !st) void'(q.pop_front());
        if (m_infl) begin
          q.push_back({memf(m_infl_addr), m_infl_pc4});
`ifdef IF_PERF_CNT_EN
          m_fetched++;
`endif
        end
      end
      m_infl = e_req;
      if (e_req) begin
        m_pc        = e_pc + 32'd4;
        m_infl_pc4  = e_pc + 32'd4;
        m_infl_addr = e_pc >> 2;
      end
    end
    if (!r) armed = 1;
    @(negedge clk);
  endtask

  initial begin
    rst_w = 1'b0;
    m_infl = 1'b0; m_pc = PC_RST; m_infl_pc4 = '0; m_infl_addr = '0;

    // Reset, then free-running fetch from PC 0
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("rst_ValidD", 32'(ValidD), 32'd0);
    chk("rst_InstrD", InstrD, 32'd0);
    chk("rst_PCPlus4D", PCPlus4D, 32'd0);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("first_valid_lat", 32'(ValidD), 32'd1);
    chk("first_instr", InstrD, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);

    // Long decode stall: queue fills, fetch stops, then drains in order
    cyc(0, 0, 0, 0);
    n_req = 0;
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
    chk("stall_req_count", 32'(n_req), 32'd4);
    chk("stall_pcf", ImemAddr, 32'd4);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);

    // Redirect with three entries queued and one in flight
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h40, 0);
    chk("redir_flush", 32'(ValidD), 32'd0);
    cyc(1, 0, 0, 0);
    chk("redir_target_instr", InstrD, memf(32'h10));
    chk("redir_target_pc4", PCPlus4D, 32'h44);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);

    // Redirect while full and stalled, then back-to-back redirects
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h80, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h100, 0); cyc(1, 1, 32'h200, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);

    // Reset with two entries queued and a request in flight
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_mid_valid", 32'(ValidD), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 7) == 0),
          $urandom, logic'($urandom_range(0, 2) == 0));

`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", PerfFetched, 32'(m_fetched));
    chk("perf_flushed", PerfFlushed, 32'(m_flushed));
`endif

    // PC wrap on the second instance
    rst_w = 1'b1;
    #1;
    chk("wrap_req0", 32'(ImemReq_w), 32'd1);
    chk("wrap_addr0", ImemAddr_w, 32'h3FFF_FFFE);
    @(negedge clk); #1;
    chk("wrap_addr1", ImemAddr_w, 32'h3FFF_FFFF);
    @(negedge clk); #1;
    chk("wrap_addr2", ImemAddr_w, 32'h0);
    chk("wrap_valid", 32'(ValidD_w), 32'd1);
    chk("wrap_pc4_0", PCPlus4D_w, 32'hFFFF_FFFC);
    chk("wrap_instr0", InstrD_w, memf(32'h3FFF_FFFE));
    @(negedge clk); #1;
    chk("wrap_pc4_1", PCPlus4D_w, 32'h0);
    chk("wrap_instr1", InstrD_w, memf(32'h3FFF_FFFF));
`ifdef IF_PERF_CNT_EN
    chk("wrap_perf_fetched", PerfFetched_w, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
